comp_const: RTL and testbench
=============================

# comp_const

Constant-equality comparator: compares a WIDTH-bit input bus against a compile-time constant (default 4'b0101) and reports the match combinationally and as registered status. Registered status includes a delayed flag, a rising-edge pulse, a sticky flag and an optional saturating match counter. Sits as a leaf decoder in datapath/control logic wherever a fixed code must be detected, such as opcode or state decode.

## Interface
Parameters:
- WIDTH, 4, width of compared input A (≥1)
- CONST, 4'b0101, constant compared against A (WIDTH bits)
- CNT_W, 8, width of match counter (≥1)

Ports:
- clk  input  1  single clock; all registers update on rising edge
- rst  input  1  reset, synchronous, active-high
- A  input  WIDTH  value under comparison
- clr_sticky  input  1  clears sticky flag
- E  output  1  combinational match: 1 iff A == CONST
- e_q  output  1  E registered one cycle
- e_rise  output  1  one-cycle pulse on a 0→1 transition of E
- sticky  output  1  set on any sampled match, held until cleared
- match_cnt  output  CNT_W  count of cycles with E=1 (only with COMP_CONST_CNT_EN)

## Operation
- E = (A == CONST), full-width bitwise equality; no don't-care bits; purely combinational, independent of clk/rst.
- e_q <= E each cycle.
- e_rise <= E & ~e_q (registered; asserts in the same cycle e_q first goes high).
- sticky: if E sampled 1 → 1; else if clr_sticky → 0; else hold. Set has priority over clear when both occur in the same cycle.
- match_cnt: +1 each cycle E sampled 1; saturates at 2^CNT_W−1 (no wrap); never decrements; cleared only by rst.
- X/Z on A: E need not be defined; no requirement beyond simulation behaviour of ==.

## Timing
- E: zero-cycle latency; valid within the same delta as A changes.
- e_q, e_rise, sticky, match_cnt: one-cycle latency from A sampled at a rising clk.
- Reset (rst=1 at a rising edge): e_q=0, e_rise=0, sticky=0, match_cnt=0. Reset overrides all other updates, including a simultaneous match. E is unaffected by rst.
- First edge after reset release with E=1: e_q=1, e_rise=1, sticky=1, match_cnt=1.
- A held at CONST for N cycles: e_rise high for exactly 1 cycle; match_cnt = min(N, 2^CNT_W−1).
- A glitching to CONST between clock edges: E follows; registered outputs do not change.
- No handshake; input is sampled every cycle.

## Configuration
- COMP_CONST_CNT_EN defined: match_cnt port and saturating counter are present as specified.
- Not defined: match_cnt port and its logic are omitted entirely; all other behaviour is unchanged.

## Test plan
- Sweep A = 0..15 (WIDTH=4, CONST=4'b0101), one value per cycle: E=1 only at A=4'b0101, 0 for the other 15 values; e_q follows one cycle later.
- Reset: hold A=4'b0101, pulse rst for 2 cycles: e_q, e_rise, sticky, match_cnt all 0 during reset; E stays 1; first edge after release gives e_rise=1, match_cnt=1.
- Hold A=4'b0101 for 5 cycles, then A=0: e_rise high for exactly 1 cycle; match_cnt=5; sticky stays 1 after A changes.
- Sticky priority: clr_sticky=1 with A=4'b0101 → sticky stays 1; clr_sticky=1 with A=0 → sticky=0 next cycle.
- Saturation (CNT_W=3): hold match for 10 cycles → match_cnt reaches 7 and holds at 7.
- Build without COMP_CONST_CNT_EN: elaborates without match_cnt; the sweep and sticky scenarios produce identical results.

Source files
------------

// File: rtl/comp_const.sv
// comp_const: detects A == CONST; E is combinational, registered status (e_q, e_rise, sticky, match_cnt) lags one cycle.
// Latency: E zero cycles; e_q/e_rise/sticky/match_cnt one cycle after A is sampled on a rising clk.
// Backpressure: none; A is sampled every cycle. Optional match_cnt port/counter present only when COMP_CONST_CNT_EN is defined.
//
// Ports:
//   clk        - single clock, all registers update on rising edge
//   rst        - synchronous active-high reset (does not affect E)
//   A          - WIDTH-bit value under comparison
//   clr_sticky - clears sticky flag (a simultaneous match wins)
//   E          - combinational match, 1 iff A == CONST
//   e_q        - E delayed one cycle
//   e_rise     - one-cycle pulse on a 0->1 transition of E
//   sticky     - set on any sampled match, held until cleared
//   match_cnt  - saturating count of matching cycles (COMP_CONST_CNT_EN only)
module comp_const #(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   CONST = 4'b0101,
    parameter int                 CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic             clr_sticky,
    output logic             E,
    output logic             e_q,
    output logic             e_rise,
`ifdef COMP_CONST_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             sticky
);

    // Elaboration-time sanity check on the sizing parameters.
    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("comp_const: WIDTH and CNT_W must be >= 1");
    end

    // Full-width equality, no don't-care bits.
    assign E = (A == CONST);

    logic e_dly_q,  e_dly_d;
    logic rise_q,   rise_d;
    logic sticky_q, sticky_d;

    always_comb begin
        e_dly_d  = E;
        // Compare against the previous sample so the pulse lines up with
        // the first cycle e_q is high.
        rise_d   = E & ~e_dly_q;
        // Set has priority over clear.
        if (E) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_dly_q  <= 1'b0;
            rise_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            e_dly_q  <= e_dly_d;
            rise_q   <= rise_d;
            sticky_q <= sticky_d;
        end
    end

    assign e_q    = e_dly_q;
    assign e_rise = rise_q;
    assign sticky = sticky_q;

`ifdef COMP_CONST_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count matching cycles, holding at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (E && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_comp_const.sv
// tb_comp_const: directed vectors with hand-computed expectations for comp_const.
// Latency: registered outputs checked 1 time unit after the rising edge that samples the inputs.
// Backpressure: none; inputs are driven every cycle from the initial block.
module tb_comp_const;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic             clr_sticky;
    logic             E;
    logic             e_q;
    logic             e_rise;
    logic             sticky;
`ifdef COMP_CONST_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    comp_const #(
        .WIDTH (WIDTH),
        .CONST (4'b0101),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .clr_sticky (clr_sticky),
        .E          (E),
        .e_q        (e_q),
        .e_rise     (e_rise),
`ifdef COMP_CONST_CNT_EN
        .match_cnt  (match_cnt),
`endif
        .sticky     (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef COMP_CONST_CNT_EN
        chk(tag, 32'(match_cnt), 32'(exp));
`endif
    endtask

    int rises;

    initial begin
        rst        = 1'b1;
        A          = '0;
        clr_sticky = 1'b0;

        // Reset state with no match.
        step();
        step();
        chk("rst_e",      32'(E),      0);
        chk("rst_eq",     32'(e_q),    0);
        chk("rst_rise",   32'(e_rise), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk_cnt("rst_cnt", 0);
        rst = 1'b0;

        // Sweep all 16 codes: only 4'b0101 matches.
        for (int v = 0; v < 16; v++) begin
            A = 4'(v);
            #1;
            chk($sformatf("sweep_e_%0d", v), 32'(E), (v == 5) ? 1 : 0);
            step();
            chk($sformatf("sweep_eq_%0d", v), 32'(e_q), (v == 5) ? 1 : 0);
            chk($sformatf("sweep_rise_%0d", v), 32'(e_rise), (v == 5) ? 1 : 0);
        end
        chk("sweep_sticky", 32'(sticky), 1);
        chk_cnt("sweep_cnt", 1);

        // Reset with A held at the constant: E stays 1, registers stay 0.
        A   = 4'b0101;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rstm_e",      32'(E),      1);
            chk("rstm_eq",     32'(e_q),    0);
            chk("rstm_rise",   32'(e_rise), 0);
            chk("rstm_sticky", 32'(sticky), 0);
            chk_cnt("rstm_cnt", 0);
        end
        rst = 1'b0;

        // First edge after release, then hold 4 more cycles (5 total).
        rises = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (e_rise) rises++;
            chk($sformatf("hold_eq_%0d", i), 32'(e_q), 1);
            chk($sformatf("hold_rise_%0d", i), 32'(e_rise), (i == 1) ? 1 : 0);
            chk("hold_sticky", 32'(sticky), 1);
            chk_cnt($sformatf("hold_cnt_%0d", i), i);
        end
        chk("hold_rises", 32'(rises), 1);

        A = '0;
        step();
        chk("drop_eq",     32'(e_q),    0);
        chk("drop_rise",   32'(e_rise), 0);
        chk("drop_sticky", 32'(sticky), 1);
        chk_cnt("drop_cnt", 5);

        // Glitch to the constant between edges: only E reacts.
        #2;
        A = 4'b0101;
        #1;
        chk("glitch_e", 32'(E), 1);
        A = '0;
        #1;
        chk("glitch_e_off", 32'(E), 0);
        step();
        chk("glitch_eq",   32'(e_q),    0);
        chk("glitch_rise", 32'(e_rise), 0);
        chk_cnt("glitch_cnt", 5);

        // Set beats clear; clear alone drops sticky.
        clr_sticky = 1'b1;
        A          = 4'b0101;
        step();
        chk("prio_sticky", 32'(sticky), 1);
        chk_cnt("prio_cnt", 6);
        A = '0;
        step();
        chk("clr_sticky", 32'(sticky), 0);
        clr_sticky = 1'b0;
        step();
        chk("clr_hold", 32'(sticky), 0);

        // Saturation: count resumes at 6, reaches 7 and holds.
        A = 4'b0101;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_cnt($sformatf("sat_cnt_%0d", i), (6 + i > 7) ? 7 : 6 + i);
            chk("sat_sticky", 32'(sticky), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
